axi_llc_burst_read_unit: RTL and testbench
==========================================

AXI_LLC_BURST_READ_UNIT -- requirements
Module: axi_llc_burst_read_unit

Interface
REQ-001 SHALL have parameter Cfg, default llc_cfg_t all-zero, static LLC configuration.
REQ-002 SHALL have parameter AxiCfg, default llc_axi_cfg_t all-zero, static AXI configuration.
REQ-003 SHALL have parameter RFifoDepth, default Cfg.NumBlocks, R beat buffer depth and issue-credit count (>=1).
REQ-004 SHALL have type parameters desc_t, way_inp_t, way_oup_t, lock_t, r_chan_t, default logic.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_i, input, 1, clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port test_i, input, 1, testmode passed to FIFOs.
REQ-009 SHALL have ports desc_i / desc_valid_i / desc_ready_o, in/in/out, desc_t/1/1, read descriptor handshake.
REQ-010 SHALL have ports way_inp_o / way_inp_valid_o / way_inp_ready_i, out/out/in, way_inp_t/1/1, data-way read request.
REQ-011 SHALL have ports way_out_i / way_out_valid_i / way_out_ready_o, in/in/out, way_oup_t/1/1, data-way response.
REQ-012 SHALL have ports r_chan_slv_o / r_chan_valid_o / r_chan_ready_i, out/out/in, r_chan_t/1/1, slave R channel.
REQ-013 SHALL have ports r_unlock_o / r_unlock_req_o / r_unlock_gnt_i, out/out/in, lock_t/1/1, line unlock handshake.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, UNLOCK; desc_ready_o=1 in IDLE, and in UNLOCK when r_unlock_gnt_i=1; 0 otherwise.
REQ-015 Descriptor accepted (valid&ready) SHALL load the register and enter ISSUE next cycle; no accept in IDLE keeps IDLE.
REQ-016 Credit counter (width clog2(RFifoDepth+1)) SHALL decrement on beat issue, increment on R pop, hold on both/neither; never exceeds RFifoDepth.
REQ-017 In ISSUE with credit>0 and desc x_resp==OKAY: way_inp_valid_o=1; issue = valid&ready.
REQ-018 In ISSUE with credit>0 and x_resp!=OKAY (bypass): no way request; beat issues unconditionally that cycle.
REQ-019 Each issued beat SHALL push meta {id, resp, last=x_last&(len==0), bypass} into meta FIFO (depth RFifoDepth).
REQ-020 After a non-final issue: len-=1; address advances by num_bytes(size) aligned for INCR; held for FIXED; for WRAP wraps to the lower boundary of the aligned block num_bytes(size)*(orig_len+1).
REQ-021 Final issue (len==0) SHALL enter UNLOCK; r_unlock_req_o=1 held until r_unlock_gnt_i; unlock index/way from descriptor register.
REQ-022 UNLOCK with gnt: accept desc_i in same cycle if valid (go ISSUE), else IDLE.
REQ-023 way_out_ready_o SHALL be 1 whenever meta head is non-bypass; credits guarantee R FIFO space, so way responses are never stalled.
REQ-024 R FIFO push: meta head non-bypass & way_out_valid_i, or meta head bypass (no way data consumed); meta pops on same push.
REQ-025 Beat data: way_out_i.data if resp OKAY, else AxiLlcVersion zero-extended; id/resp/last from meta.
REQ-026 R FIFO (fall-through, depth RFifoDepth) drives R channel; r_chan_valid_o=~empty; pop=valid&ready.
REQ-027 way_inp_o: RChanUnit, we=0, strb=0, data=0, index/blk_offset from descriptor address.
REQ-028 R beat order SHALL equal issue order; ID interleaving never occurs.

Reset
REQ-029 While rst_i=1 (sampled at clock edge): FSM IDLE, descriptor register 0, credits=RFifoDepth, both FIFOs empty.
REQ-030 While rst_i=1, desc_ready_o, way_inp_valid_o, way_out_ready_o, r_chan_valid_o, r_unlock_req_o SHALL be 0.
REQ-031 Reset mid-burst SHALL drop all in-flight meta and beats; no unlock request issued.

Structure
REQ-032 rd_state_e enum and wrap-address function SHALL be in axi_llc_pkg; r_meta_t local.
REQ-033 SHALL reuse common_cells fifo_v3 twice (meta, R); no other sub-module.

Verification
REQ-034 INCR len=3 size=max, OKAY, latency 1, ready=1 -> 4 beats, last on 4th, one unlock after 4th issue.
REQ-035 WRAP len=3 size=3 addr 0x18 -> way offsets 0x18,0x00,0x08,0x10.
REQ-036 RFifoDepth=2, r_chan_ready_i=0, len=7 -> exactly 2 way requests, then stall; resume on ready, 8 beats total.
REQ-037 x_resp=SLVERR len=1 -> 2 beats data=AxiLlcVersion, zero way requests, one unlock.
REQ-038 r_unlock_gnt_i held 0 for 5 cycles, second desc valid -> desc_ready_o 0 until gnt, accepted same cycle as gnt.
REQ-039 rst_i asserted after 2 of 4 issued beats -> all outputs 0 next cycle; credits=RFifoDepth, no residual beat.

Source files
------------

// File: rtl/axi_llc_burst_read_unit_pkg.sv
// Shared types, constants and address helpers for the LLC read path.
// Holds the read FSM state encoding and the AXI burst address math.
package axi_llc_pkg;

   typedef struct packed {
      int unsigned SetAssociativity;
      int unsigned NumLines;
      int unsigned NumBlocks;
      int unsigned BlockSize;
   } llc_cfg_t;

   typedef struct packed {
      int unsigned SlvPortIdWidth;
      int unsigned AddrWidthFull;
      int unsigned DataWidthFull;
   } llc_axi_cfg_t;

   localparam int unsigned IdWidth      = 4;
   localparam int unsigned AddrWidth    = 32;
   localparam int unsigned DataWidth    = 64;
   localparam int unsigned ByteOffWidth = 3;
   localparam int unsigned BlkOffWidth  = 3;
   localparam int unsigned IndexWidth   = 6;
   localparam int unsigned NumWays      = 4;

   localparam logic [31:0] AxiLlcVersion = 32'h2021_0101;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [1:0] {
      Idle,
      Issue,
      Unlock
   } rd_state_e;

   typedef enum logic [1:0] {
      EvictUnit,
      RefilUnit,
      WChanUnit,
      RChanUnit
   } cache_unit_e;

   typedef struct packed {
      logic [IdWidth-1:0]   a_x_id;
      logic [AddrWidth-1:0] a_x_addr;
      logic [7:0]           a_x_len;
      logic [2:0]           a_x_size;
      logic [1:0]           a_x_burst;
      logic [1:0]           x_resp;
      logic                 x_last;
      logic [NumWays-1:0]   way_ind;
   } llc_desc_t;

   typedef struct packed {
      cache_unit_e            cache_unit;
      logic [NumWays-1:0]     way_ind;
      logic [IndexWidth-1:0]  line_addr;
      logic [BlkOffWidth-1:0] blk_offset;
      logic                   we;
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
   } llc_way_inp_t;

   typedef struct packed {
      cache_unit_e          cache_unit;
      logic [DataWidth-1:0] data;
   } llc_way_oup_t;

   typedef struct packed {
      logic [IndexWidth-1:0] index;
      logic [NumWays-1:0]    way_ind;
   } llc_lock_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
   } llc_r_chan_t;

   function automatic logic [AddrWidth-1:0] axi_num_bytes(
      input logic [2:0] size
   );
      return AddrWidth'(1) << size;
   endfunction

   // Next beat address of a WRAP burst; len is the original beat count - 1.
   function automatic logic [AddrWidth-1:0] axi_wrap_addr(
      input logic [AddrWidth-1:0] addr,
      input logic [2:0]           size,
      input logic [7:0]           len
   );
      logic [AddrWidth-1:0] num;
      logic [AddrWidth-1:0] span;
      logic [AddrWidth-1:0] lower;
      logic [AddrWidth-1:0] nxt;
      num   = axi_num_bytes(size);
      span  = num * (AddrWidth'(len) + AddrWidth'(1));
      lower = addr & ~(span - AddrWidth'(1));
      nxt   = (addr & ~(num - AddrWidth'(1))) + num;
      return (nxt >= lower + span) ? lower : nxt;
   endfunction

endpackage

// File: rtl/axi_llc_burst_read_unit_fifo.sv
// Generic FIFO with optional fall-through, flush and usage count.
// Port list matches the common_cells fifo_v3 block.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter type         dtype        = logic [DATA_WIDTH-1:0],
   parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  dtype                  data_i,
   input  logic                  push_i,
   output dtype                  data_o,
   input  logic                  pop_i
);

   logic [ADDR_DEPTH-1:0] rd_q, rd_d;
   logic [ADDR_DEPTH-1:0] wr_q, wr_d;
   logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
   logic                  we;
   dtype                  mem_q [DEPTH];
   logic                  unused_testmode;

   assign unused_testmode = testmode_i;
   assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
   assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
   assign usage_o = cnt_q[ADDR_DEPTH-1:0];

   function automatic logic [ADDR_DEPTH-1:0] ptr_inc(
      input logic [ADDR_DEPTH-1:0] p
   );
      return (p == ADDR_DEPTH'(DEPTH-1)) ? '0 : p + ADDR_DEPTH'(1);
   endfunction

   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      we     = 1'b0;
      data_o = mem_q[rd_q];
      if (push_i && !full_o) begin
         we    = 1'b1;
         wr_d  = ptr_inc(wr_q);
         cnt_d = cnt_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
         rd_d  = ptr_inc(rd_q);
         cnt_d = (push_i && !full_o) ? cnt_q : cnt_q - 1'b1;
      end
      // Empty and bypassed: data flies straight through, nothing stored.
      if (FALL_THROUGH && cnt_q == '0 && push_i) begin
         data_o = data_i;
         if (pop_i) begin
            cnt_d = cnt_q;
            rd_d  = rd_q;
            wr_d  = wr_q;
            we    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we && !flush_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/axi_llc_burst_read_unit.sv
// LLC read burst engine: splits a descriptor into data-way reads and
// returns R beats in order, then releases the line lock.
module axi_llc_burst_read_unit
   import axi_llc_pkg::*;
#(
   parameter llc_cfg_t     Cfg        = llc_cfg_t'(0),
   parameter llc_axi_cfg_t AxiCfg     = llc_axi_cfg_t'(0),
   parameter int unsigned  RFifoDepth = Cfg.NumBlocks,
   parameter type          desc_t     = llc_desc_t,
   parameter type          way_inp_t  = llc_way_inp_t,
   parameter type          way_oup_t  = llc_way_oup_t,
   parameter type          lock_t     = llc_lock_t,
   parameter type          r_chan_t   = llc_r_chan_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     test_i,
   input  desc_t    desc_i,
   input  logic     desc_valid_i,
   output logic     desc_ready_o,
   output way_inp_t way_inp_o,
   output logic     way_inp_valid_o,
   input  logic     way_inp_ready_i,
   input  way_oup_t way_out_i,
   input  logic     way_out_valid_i,
   output logic     way_out_ready_o,
   output r_chan_t  r_chan_slv_o,
   output logic     r_chan_valid_o,
   input  logic     r_chan_ready_i,
   output lock_t    r_unlock_o,
   output logic     r_unlock_req_o,
   input  logic     r_unlock_gnt_i
);

   localparam int unsigned Depth    = (RFifoDepth == 0) ? 1 : RFifoDepth;
   localparam int unsigned CntWidth = $clog2(Depth + 1);
   localparam int unsigned MaxSize  = (AxiCfg.DataWidthFull < 16) ?
                                      ByteOffWidth :
                                      $clog2(AxiCfg.DataWidthFull / 8);
   localparam logic [2:0]  SizeMax  = 3'(MaxSize);
   localparam int unsigned IdxLsb   = ByteOffWidth + BlkOffWidth;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [1:0]         resp;
      logic               last;
      logic               bypass;
   } r_meta_t;

   rd_state_e            state_q, state_d;
   desc_t                desc_q, desc_d;
   logic [7:0]           wrap_len_q, wrap_len_d;
   logic [CntWidth-1:0]  credit_q, credit_d;

   logic                 issue, bypass, load;
   logic [2:0]           size_eff;
   logic [AddrWidth-1:0] nbytes, next_addr;
   r_meta_t              meta_in, meta_out;
   logic                 meta_empty, meta_full, meta_pop;
   r_chan_t              r_in;
   logic                 r_push, r_pop, r_empty, r_full;
   logic [$clog2(Depth) > 0 ? $clog2(Depth)-1 : 0:0] meta_usage, r_usage;
   logic                 unused_sig;

   assign bypass = (desc_q.x_resp != RespOkay);

   always_comb begin
      size_eff  = (desc_q.a_x_size > SizeMax) ? SizeMax : desc_q.a_x_size;
      nbytes    = axi_num_bytes(size_eff);
      next_addr = (desc_q.a_x_addr & ~(nbytes - AddrWidth'(1))) + nbytes;
      unique case (desc_q.a_x_burst)
         BurstFixed: next_addr = desc_q.a_x_addr;
         BurstWrap:  next_addr = axi_wrap_addr(desc_q.a_x_addr,
                                               size_eff, wrap_len_q);
         default:    ;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      desc_d          = desc_q;
      wrap_len_d      = wrap_len_q;
      desc_ready_o    = 1'b0;
      way_inp_valid_o = 1'b0;
      r_unlock_req_o  = 1'b0;
      issue           = 1'b0;
      load            = 1'b0;
      unique case (state_q)
         Idle: begin
            desc_ready_o = 1'b1;
            load         = desc_valid_i;
         end
         Issue: begin
            if (credit_q != '0) begin
               way_inp_valid_o = ~bypass;
               issue           = bypass | way_inp_ready_i;
            end
            if (issue) begin
               if (desc_q.a_x_len == '0) begin
                  state_d = Unlock;
               end else begin
                  desc_d.a_x_len  = desc_q.a_x_len - 8'd1;
                  desc_d.a_x_addr = next_addr;
               end
            end
         end
         Unlock: begin
            r_unlock_req_o = 1'b1;
            if (r_unlock_gnt_i) begin
               desc_ready_o = 1'b1;
               load         = desc_valid_i;
               state_d      = Idle;
            end
         end
         default: state_d = Idle;
      endcase
      if (load) begin
         desc_d     = desc_i;
         wrap_len_d = desc_i.a_x_len;
         state_d    = Issue;
      end
      if (rst_i) begin
         desc_ready_o    = 1'b0;
         way_inp_valid_o = 1'b0;
         r_unlock_req_o  = 1'b0;
         issue           = 1'b0;
      end
   end

   always_comb begin
      credit_d = credit_q;
      if (issue && !r_pop) begin
         credit_d = credit_q - CntWidth'(1);
      end else if (!issue && r_pop && credit_q != CntWidth'(Depth)) begin
         credit_d = credit_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= Idle;
         desc_q     <= '0;
         wrap_len_q <= '0;
         credit_q   <= CntWidth'(Depth);
      end else begin
         state_q    <= state_d;
         desc_q     <= desc_d;
         wrap_len_q <= wrap_len_d;
         credit_q   <= credit_d;
      end
   end

   always_comb begin
      way_inp_o            = '0;
      way_inp_o.cache_unit = RChanUnit;
      way_inp_o.way_ind    = desc_q.way_ind;
      way_inp_o.line_addr  = desc_q.a_x_addr[IdxLsb +: IndexWidth];
      way_inp_o.blk_offset = desc_q.a_x_addr[ByteOffWidth +: BlkOffWidth];
      r_unlock_o           = '0;
      r_unlock_o.index     = desc_q.a_x_addr[IdxLsb +: IndexWidth];
      r_unlock_o.way_ind   = desc_q.way_ind;
   end

   always_comb begin
      meta_in.id     = desc_q.a_x_id;
      meta_in.resp   = desc_q.x_resp;
      meta_in.last   = desc_q.x_last & (desc_q.a_x_len == '0);
      meta_in.bypass = bypass;
   end

   // Credits reserve R FIFO space, so way data is never back-pressured.
   assign way_out_ready_o = ~rst_i & ~meta_empty & ~meta_out.bypass;
   assign r_push   = ~rst_i & ~meta_empty &
                     (meta_out.bypass | way_out_valid_i);
   assign meta_pop = r_push;

   always_comb begin
      r_in      = '0;
      r_in.id   = meta_out.id;
      r_in.resp = meta_out.resp;
      r_in.last = meta_out.last;
      r_in.data = (meta_out.resp == RespOkay) ?
                  way_out_i.data : DataWidth'(AxiLlcVersion);
   end

   assign r_chan_valid_o = ~rst_i & ~r_empty;
   assign r_pop          = r_chan_valid_o & r_chan_ready_i;

   fifo_v3 #(
      .FALL_THROUGH(1'b0),
      .DEPTH       (Depth),
      .dtype       (r_meta_t)
   ) i_meta_fifo (
      .clk_i     (clk_i),
      .rst_ni    (1'b1),
      .flush_i   (rst_i),
      .testmode_i(test_i),
      .full_o    (meta_full),
      .empty_o   (meta_empty),
      .usage_o   (meta_usage),
      .data_i    (meta_in),
      .push_i    (issue),
      .data_o    (meta_out),
      .pop_i     (meta_pop)
   );

   fifo_v3 #(
      .FALL_THROUGH(1'b1),
      .DEPTH       (Depth),
      .dtype       (r_chan_t)
   ) i_r_fifo (
      .clk_i     (clk_i),
      .rst_ni    (1'b1),
      .flush_i   (rst_i),
      .testmode_i(test_i),
      .full_o    (r_full),
      .empty_o   (r_empty),
      .usage_o   (r_usage),
      .data_i    (r_in),
      .push_i    (r_push),
      .data_o    (r_chan_slv_o),
      .pop_i     (r_pop)
   );

   assign unused_sig = ^{meta_full, r_full, meta_usage, r_usage,
                         way_out_i.cache_unit};

endmodule

// File: tb/tb_axi_llc_burst_read_unit.sv
// Directed bench for the LLC burst read unit with a 1-cycle way model.
// Checks beat order, data, wrap offsets, credits, bypass, unlock, reset.
module tb_axi_llc_burst_read_unit;
   import axi_llc_pkg::*;

   localparam llc_cfg_t CfgTb = '{SetAssociativity: 4, NumLines: 64,
                                  NumBlocks: 8, BlockSize: 64};
   localparam llc_axi_cfg_t AxiCfgTb = '{SlvPortIdWidth: 4,
                                         AddrWidthFull: 32,
                                         DataWidthFull: 64};

   logic         clk = 1'b0;
   logic         rst_i, test_i;
   llc_desc_t    desc_i;
   logic         desc_valid_i, desc_ready_o;
   llc_way_inp_t way_inp_o;
   logic         way_inp_valid_o, way_inp_ready_i;
   llc_way_oup_t way_out_i;
   logic         way_out_valid_i, way_out_ready_o;
   llc_r_chan_t  r_chan_slv_o;
   logic         r_chan_valid_o, r_chan_ready_i;
   llc_lock_t    r_unlock_o;
   logic         r_unlock_req_o, r_unlock_gnt_i;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [63:0]  resp_q[$];
   logic [2:0]   req_blk[$];
   llc_r_chan_t  beat_q[$];
   int           n_unlock = 0;
   llc_lock_t    last_lock;

   always #5 clk = ~clk;

   axi_llc_burst_read_unit #(
      .Cfg       (CfgTb),
      .AxiCfg    (AxiCfgTb),
      .RFifoDepth(2),
      .desc_t    (llc_desc_t),
      .way_inp_t (llc_way_inp_t),
      .way_oup_t (llc_way_oup_t),
      .lock_t    (llc_lock_t),
      .r_chan_t  (llc_r_chan_t)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .test_i         (test_i),
      .desc_i         (desc_i),
      .desc_valid_i   (desc_valid_i),
      .desc_ready_o   (desc_ready_o),
      .way_inp_o      (way_inp_o),
      .way_inp_valid_o(way_inp_valid_o),
      .way_inp_ready_i(way_inp_ready_i),
      .way_out_i      (way_out_i),
      .way_out_valid_i(way_out_valid_i),
      .way_out_ready_o(way_out_ready_o),
      .r_chan_slv_o   (r_chan_slv_o),
      .r_chan_valid_o (r_chan_valid_o),
      .r_chan_ready_i (r_chan_ready_i),
      .r_unlock_o     (r_unlock_o),
      .r_unlock_req_o (r_unlock_req_o),
      .r_unlock_gnt_i (r_unlock_gnt_i)
   );

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [5:0] idx,
                                            input logic [2:0] blk);
      logic [63:0] d;
      d        = 64'hCAFE_0000_0000_0000;
      d[13:8]  = idx;
      d[2:0]   = blk;
      return d;
   endfunction

   function automatic llc_desc_t mk(input logic [3:0] id,
                                    input logic [31:0] addr,
                                    input logic [7:0] len,
                                    input logic [1:0] burst,
                                    input logic [1:0] xresp);
      llc_desc_t d;
      d           = '0;
      d.a_x_id    = id;
      d.a_x_addr  = addr;
      d.a_x_len   = len;
      d.a_x_size  = 3'd3;
      d.a_x_burst = burst;
      d.x_resp    = xresp;
      d.x_last    = 1'b1;
      d.way_ind   = 4'b0010;
      return d;
   endfunction

   // Observers sample mid-cycle; the way model answers 1 cycle later.
   initial forever begin
      @(negedge clk);
      if (rst_i) begin
         resp_q.delete();
      end else begin
         if (way_out_valid_i && way_out_ready_o)
            void'(resp_q.pop_front());
         if (way_inp_valid_o && way_inp_ready_i) begin
            resp_q.push_back(mem_data(way_inp_o.line_addr,
                                      way_inp_o.blk_offset));
            req_blk.push_back(way_inp_o.blk_offset);
         end
         if (r_chan_valid_o && r_chan_ready_i)
            beat_q.push_back(r_chan_slv_o);
         if (r_unlock_req_o && r_unlock_gnt_i) begin
            n_unlock++;
            last_lock = r_unlock_o;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      way_out_valid_i      = (resp_q.size() != 0);
      way_out_i.cache_unit = RChanUnit;
      way_out_i.data       = (resp_q.size() != 0) ? resp_q[0] : 64'h0;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      beat_q.delete();
      req_blk.delete();
      n_unlock = 0;
   endtask

   task automatic send(input llc_desc_t d);
      int t;
      t            = 0;
      desc_i       = d;
      desc_valid_i = 1'b1;
      @(negedge clk);
      while (!desc_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("desc_accept_timeout", 64'(t < 50), 64'd1);
      @(posedge clk);
      #1;
      desc_valid_i = 1'b0;
   endtask

   task automatic wait_beats(input int n, input string tag);
      int t;
      t = 0;
      while (beat_q.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(tag, 64'(beat_q.size()), 64'(n));
      tick(3);
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_desc_ready"},  64'(desc_ready_o),    64'd0);
      check({tag, "_way_valid"},   64'(way_inp_valid_o), 64'd0);
      check({tag, "_way_ready"},   64'(way_out_ready_o), 64'd0);
      check({tag, "_r_valid"},     64'(r_chan_valid_o),  64'd0);
      check({tag, "_unlock_req"},  64'(r_unlock_req_o),  64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] exp34 [4];
      logic [2:0]  exp35 [4];
      int          t;
      exp34 = '{64'hCAFE_0000_0000_0100, 64'hCAFE_0000_0000_0101,
                64'hCAFE_0000_0000_0102, 64'hCAFE_0000_0000_0103};
      exp35 = '{3'd3, 3'd0, 3'd1, 3'd2};
      rst_i           = 1'b1;
      test_i          = 1'b0;
      desc_i          = '0;
      desc_valid_i    = 1'b0;
      way_inp_ready_i = 1'b1;
      r_chan_ready_i  = 1'b1;
      r_unlock_gnt_i  = 1'b1;
      tick(3);
      @(negedge clk);
      check_idle_outs("reset");
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("idle_desc_ready", 64'(desc_ready_o), 64'd1);
      tick(1);

      // INCR len 3 at 0x40: index 1, blocks 0..3
      clear_logs();
      send(mk(4'd5, 32'h40, 8'd3, BurstIncr, RespOkay));
      wait_beats(4, "incr_beats");
      check("incr_way_reqs", 64'(req_blk.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("incr_data", beat_q[i].data, exp34[i]);
         check("incr_last", 64'(beat_q[i].last), 64'(i == 3));
      end
      check("incr_id", 64'(beat_q[0].id), 64'd5);
      check("incr_resp", 64'(beat_q[3].resp), 64'd0);
      check("incr_unlocks", 64'(n_unlock), 64'd1);
      check("incr_lock_idx", 64'(last_lock.index), 64'd1);
      check("incr_lock_way", 64'(last_lock.way_ind), 64'd2);

      // WRAP len 3 at 0x18: offsets 0x18,0x00,0x08,0x10
      clear_logs();
      send(mk(4'd2, 32'h18, 8'd3, BurstWrap, RespOkay));
      wait_beats(4, "wrap_beats");
      for (int i = 0; i < 4; i++)
         check("wrap_blk", 64'(req_blk[i]), 64'(exp35[i]));
      check("wrap_data1", beat_q[1].data, 64'hCAFE_0000_0000_0000);

      // Two credits: R stalled, only two way reads go out
      clear_logs();
      r_chan_ready_i = 1'b0;
      send(mk(4'd1, 32'h0, 8'd7, BurstIncr, RespOkay));
      tick(20);
      check("stall_way_reqs", 64'(req_blk.size()), 64'd2);
      check("stall_beats", 64'(beat_q.size()), 64'd0);
      check("stall_r_valid", 64'(r_chan_valid_o), 64'd1);
      r_chan_ready_i = 1'b1;
      wait_beats(8, "stall_beats_total");
      check("stall_way_total", 64'(req_blk.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         check("stall_order", beat_q[i].data,
               64'hCAFE_0000_0000_0000 | 64'(i));
      check("stall_last7", 64'(beat_q[7].last), 64'd1);
      check("stall_last6", 64'(beat_q[6].last), 64'd0);

      // Error response: bypass with version data, no way traffic
      clear_logs();
      send(mk(4'd3, 32'h100, 8'd1, BurstIncr, RespSlvErr));
      wait_beats(2, "err_beats");
      check("err_way_reqs", 64'(req_blk.size()), 64'd0);
      check("err_data0", beat_q[0].data, 64'h0000_0000_2021_0101);
      check("err_data1", beat_q[1].data, 64'h0000_0000_2021_0101);
      check("err_resp", 64'(beat_q[1].resp), 64'(RespSlvErr));
      check("err_last0", 64'(beat_q[0].last), 64'd0);
      check("err_last1", 64'(beat_q[1].last), 64'd1);
      check("err_unlocks", 64'(n_unlock), 64'd1);

      // Grant held low: next descriptor waits, accepted with the grant
      clear_logs();
      r_unlock_gnt_i = 1'b0;
      send(mk(4'd4, 32'h80, 8'd0, BurstIncr, RespOkay));
      desc_i       = mk(4'd6, 32'hC0, 8'd0, BurstIncr, RespOkay);
      desc_valid_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!r_unlock_req_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("gnt_req_seen", 64'(r_unlock_req_o), 64'd1);
      for (int k = 0; k < 5; k++) begin
         check("gnt_wait_ready", 64'(desc_ready_o), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      r_unlock_gnt_i = 1'b1;
      @(negedge clk);
      check("gnt_ready", 64'(desc_ready_o), 64'd1);
      check("gnt_req", 64'(r_unlock_req_o), 64'd1);
      @(posedge clk);
      #1;
      desc_valid_i = 1'b0;
      @(negedge clk);
      check("gnt_next_issue", 64'(way_inp_valid_o), 64'd1);
      check("gnt_next_idx", 64'(way_inp_o.line_addr), 64'd3);
      wait_beats(2, "gnt_beats");
      check("gnt_data0", beat_q[0].data, 64'hCAFE_0000_0000_0200);
      check("gnt_data1", beat_q[1].data, 64'hCAFE_0000_0000_0300);
      check("gnt_unlocks", 64'(n_unlock), 64'd2);

      // Reset mid-burst after two issued beats
      clear_logs();
      r_chan_ready_i = 1'b0;
      send(mk(4'd7, 32'h40, 8'd3, BurstIncr, RespOkay));
      tick(10);
      check("rst_pre_reqs", 64'(req_blk.size()), 64'd2);
      rst_i = 1'b1;
      @(negedge clk);
      check_idle_outs("midrst");
      tick(2);
      rst_i          = 1'b0;
      r_chan_ready_i = 1'b1;
      clear_logs();
      tick(10);
      check("rst_no_beats", 64'(beat_q.size()), 64'd0);
      check("rst_no_unlock", 64'(n_unlock), 64'd0);
      check("rst_r_valid", 64'(r_chan_valid_o), 64'd0);
      check("rst_desc_ready", 64'(desc_ready_o), 64'd1);
      r_chan_ready_i = 1'b0;
      send(mk(4'd8, 32'h0, 8'd7, BurstIncr, RespOkay));
      tick(20);
      check("rst_credits", 64'(req_blk.size()), 64'd2);
      r_chan_ready_i = 1'b1;
      wait_beats(8, "rst_after_beats");
      check("rst_after_id", 64'(beat_q[0].id), 64'd8);
      check("rst_after_data", beat_q[0].data, 64'hCAFE_0000_0000_0000);
      check("rst_after_unlock", 64'(n_unlock), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
